// File: rtl/inst_fetcher_pkg.sv
// Shared widths, PC step and fetch FSM encoding for the instruction fetch stage.
package inst_fetcher_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    F_LOOKUP = 1'b0,
    F_MISS   = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped one-instruction-per-line I-cache: combinational lookup, synchronous fill.
module inst_fetcher_icache
  import inst_fetcher_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:2]   rd_addr_i,
  output logic                hit_o,
  output logic [INST_W-1:0]   inst_o,
  input  logic                we_i,
  input  logic [ADDR_W-1:2]   wr_addr_i,
  input  logic [INST_W-1:0]   wr_inst_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;

  assign rd_idx = rd_addr_i[IDX_W+1:2];
  assign rd_tag = rd_addr_i[ADDR_W-1:IDX_W+2];
  assign wr_idx = wr_addr_i[IDX_W+1:2];
  assign wr_tag = wr_addr_i[ADDR_W-1:IDX_W+2];

  assign hit_o  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign inst_o = data_mem[rd_idx];

  // Only the valid bits need clearing; stale tag/data behind a clear bit is never used.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_inst_i;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: PC, I-cache lookup, miss handling against memctrl, pushes {inst, pc} to the IQ.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int                ICACHE_LINES = 64,
  parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              oMC_en,
  output logic [ADDR_W-1:0] oMC_addr,
  input  logic              iMC_done,
  input  logic [INST_W-1:0] iMC_inst,
  input  logic              iIQ_full,
  output logic              oIQ_en,
  output logic [INST_W-1:0] oIQ_inst,
  output logic [ADDR_W-1:0] oIQ_pc,
  input  logic              iJP_en,
  input  logic [ADDR_W-1:0] iJP_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_jp_q, pend_jp_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              mc_en_q, mc_en_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic              iq_en_q, iq_en_d;
  logic [INST_W-1:0] iq_inst_q, iq_inst_d;
  logic [ADDR_W-1:0] iq_pc_q, iq_pc_d;

  logic              hit;
  logic [INST_W-1:0] line_inst;
  logic              cache_we;

  inst_fetcher_icache #(
    .LINES (ICACHE_LINES)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_i (pc_q[ADDR_W-1:2]),
    .hit_o     (hit),
    .inst_o    (line_inst),
    .we_i      (cache_we),
    .wr_addr_i (mc_addr_q[ADDR_W-1:2]),
    .wr_inst_i (iMC_inst)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_jp_d = pend_jp_q;
    pend_pc_d = pend_pc_q;
    mc_en_d   = mc_en_q;
    mc_addr_d = mc_addr_q;
    iq_en_d   = iq_en_q;
    iq_inst_d = iq_inst_q;
    iq_pc_d   = iq_pc_q;
    cache_we  = 1'b0;
    if (rdy) begin
      unique case (state_q)
        F_LOOKUP: begin
          if (iJP_en) begin
            pc_d    = iJP_pc;
            iq_en_d = 1'b0;
          end else if (hit) begin
            if (!iIQ_full) begin
              iq_en_d   = 1'b1;
              iq_inst_d = line_inst;
              iq_pc_d   = pc_q;
              pc_d      = pc_q + PC_STEP;
            end else begin
              iq_en_d = 1'b0;
            end
          end else begin
            mc_en_d   = 1'b1;
            mc_addr_d = {pc_q[ADDR_W-1:2], 2'b00};
            state_d   = F_MISS;
            iq_en_d   = 1'b0;
          end
        end
        F_MISS: begin
          // memctrl cannot abort a read, so a redirect here is parked until the fill lands.
          iq_en_d = 1'b0;
          if (iJP_en) begin
            pend_pc_d = iJP_pc;
            pend_jp_d = 1'b1;
          end
          if (iMC_done) begin
            cache_we  = 1'b1;
            mc_en_d   = 1'b0;
            state_d   = F_LOOKUP;
            pend_jp_d = 1'b0;
            if (iJP_en) begin
              pc_d = iJP_pc;
            end else if (pend_jp_q) begin
              pc_d = pend_pc_q;
            end
          end
        end
        default: state_d = F_LOOKUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= F_LOOKUP;
      pc_q      <= RESET_PC;
      pend_jp_q <= 1'b0;
      pend_pc_q <= '0;
      mc_en_q   <= 1'b0;
      mc_addr_q <= '0;
      iq_en_q   <= 1'b0;
      iq_inst_q <= '0;
      iq_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_jp_q <= pend_jp_d;
      pend_pc_q <= pend_pc_d;
      mc_en_q   <= mc_en_d;
      mc_addr_q <= mc_addr_d;
      iq_en_q   <= iq_en_d;
      iq_inst_q <= iq_inst_d;
      iq_pc_q   <= iq_pc_d;
    end
  end

  assign oMC_en   = mc_en_q;
  assign oMC_addr = mc_addr_q;
  assign oIQ_en   = iq_en_q;
  assign oIQ_inst = iq_inst_q;
  assign oIQ_pc   = iq_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a 5-cycle memctrl responder and a request log.
module tb_inst_fetcher;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        oMC_en;
  logic [31:0] oMC_addr;
  logic        iMC_done;
  logic [31:0] iMC_inst;
  logic        iIQ_full;
  logic        oIQ_en;
  logic [31:0] oIQ_inst;
  logic [31:0] oIQ_pc;
  logic        iJP_en;
  logic [31:0] iJP_pc;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [1024];
  int          mdl_cnt;

  logic        mc_prev   = 1'b0;
  logic [31:0] addr_prev = 32'h0;
  int          stab_err  = 0;
  logic [31:0] req_q [$];

  inst_fetcher #(
    .ICACHE_LINES (64),
    .RESET_PC     (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .oMC_en   (oMC_en),
    .oMC_addr (oMC_addr),
    .iMC_done (iMC_done),
    .iMC_inst (iMC_inst),
    .iIQ_full (iIQ_full),
    .oIQ_en   (oIQ_en),
    .oIQ_inst (oIQ_inst),
    .oIQ_pc   (oIQ_pc),
    .iJP_en   (iJP_en),
    .iJP_pc   (iJP_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  // memctrl stand-in: answers a held request on the 5th enabled cycle after it rises.
  always @(posedge clk) begin
    if (rst) begin
      mdl_cnt  <= 0;
      iMC_done <= 1'b0;
      iMC_inst <= 32'h0;
    end else if (rdy) begin
      iMC_done <= 1'b0;
      if (oMC_en && !iMC_done) begin
        if (mdl_cnt == 4) begin
          iMC_done <= 1'b1;
          iMC_inst <= mem[oMC_addr[11:2]];
          mdl_cnt  <= 0;
        end else begin
          mdl_cnt <= mdl_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rdy) begin
      if (oMC_en && !mc_prev) req_q.push_back(oMC_addr);
      if (oMC_en && mc_prev && oMC_addr !== addr_prev) stab_err <= stab_err + 1;
      mc_prev   <= oMC_en;
      addr_prev <= oMC_addr;
    end
  end

  function automatic logic [31:0] req_at(input int i);
    return (i < req_q.size()) ? req_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_push(input string tag, input logic [31:0] exp_pc, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oIQ_en && n < budget);
    chk({tag, "_en"},   {31'd0, oIQ_en}, 32'd1);
    chk({tag, "_pc"},   oIQ_pc,   exp_pc);
    chk({tag, "_inst"}, oIQ_inst, inst_of(exp_pc));
    $display("push %-10s pc=%h inst=%h after %0d cycles", tag, oIQ_pc, oIQ_inst, n);
  endtask

  task automatic jump(input logic [31:0] target);
    iJP_en = 1'b1;
    iJP_pc = target;
    @(negedge clk);
    iJP_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = inst_of(i * 4);
    rst = 1'b1; rdy = 1'b1; iIQ_full = 1'b0; iJP_en = 1'b0; iJP_pc = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mc_en",   {31'd0, oMC_en}, 32'd0);
    chk("rst_mc_addr", oMC_addr, 32'h0);
    chk("rst_iq_en",   {31'd0, oIQ_en}, 32'd0);
    chk("rst_iq_inst", oIQ_inst, 32'h0);
    chk("rst_iq_pc",   oIQ_pc,   32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: cold start, request one cycle after the first lookup
    @(negedge clk);
    chk("cold_req_en",   {31'd0, oMC_en}, 32'd1);
    chk("cold_req_addr", oMC_addr, 32'h0);
    wait_push("cold0", 32'h0, 40);
    wait_push("cold4", 32'h4, 40);
    chk("cold_req0", req_at(0), 32'h0);
    chk("cold_req1", req_at(1), 32'h4);

    // 2: loop back to 0, both lines now hit back-to-back
    jump(32'h0);
    wait_push("loop0", 32'h0, 3);
    chk("loop_no_req", {31'd0, oMC_en}, 32'd0);
    wait_push("loop4", 32'h4, 1);
    chk("loop_req_cnt", req_q.size(), 32'd2);

    // 3: IQ full for three cycles on a hit
    jump(32'h0);
    iIQ_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_no_push", {31'd0, oIQ_en}, 32'd0);
    end
    iIQ_full = 1'b0;
    wait_push("full_rel0", 32'h0, 1);
    wait_push("full_rel4", 32'h4, 1);

    // 4: redirect two cycles into the miss at 0x8
    @(negedge clk);
    chk("miss8_en",   {31'd0, oMC_en}, 32'd1);
    chk("miss8_addr", oMC_addr, 32'h8);
    jump(32'h100);
    wait_push("redir100", 32'h100, 60);
    chk("redir_req2", req_at(2), 32'h8);
    chk("redir_req3", req_at(3), 32'h100);
    jump(32'h8);
    wait_push("filled8", 32'h8, 3);
    chk("filled8_req_cnt", req_q.size(), 32'd4);

    // 5: 0x0 and 0x100 share line 0 and evict each other
    jump(32'h0);
    wait_push("alias0", 32'h0, 40);
    chk("alias0_req", req_at(4), 32'h0);
    jump(32'h100);
    wait_push("alias100", 32'h100, 40);
    chk("alias100_req", req_at(5), 32'h100);

    // 6: rdy low freezes a pending push and a redirect; then rdy low and rst mid-miss
    rdy = 1'b0; iJP_en = 1'b1; iJP_pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_iq_en", {31'd0, oIQ_en}, 32'd1);
      chk("hold_iq_pc", oIQ_pc, 32'h100);
    end
    rdy = 1'b1;
    @(negedge clk);
    iJP_en = 1'b0;
    @(negedge clk);
    chk("miss200_en",   {31'd0, oMC_en}, 32'd1);
    chk("miss200_addr", oMC_addr, 32'h200);
    @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_mc_en",   {31'd0, oMC_en}, 32'd1);
      chk("stall_mc_addr", oMC_addr, 32'h200);
      chk("stall_iq_en",   {31'd0, oIQ_en}, 32'd0);
    end
    rdy = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_mc_en", {31'd0, oMC_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_push("post_rst0", 32'h0, 40);
    chk("post_rst_req6", req_at(6), 32'h200);
    chk("post_rst_req7", req_at(7), 32'h0);
    chk("post_rst_req_cnt", req_q.size(), 32'd8);

    chk("mc_addr_stable", stab_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
